// File: rtl/pol_rd_sched_if.sv
// Bundle of the pooling-core request/return bus, the GLB feature-map read
// port and the CCU enable/idle pair handled by pol_rd_sched.
interface pol_rd_sched_if #(
  parameter int POOL_CORE      = 6,
  parameter int POOL_COMP_CORE = 64,
  parameter int IDX_WIDTH      = 10,
  parameter int ACT_WIDTH      = 8
) ();

  logic [POOL_CORE-1:0]                CCUMIF_PortEn;
  logic                                MIFCCU_Idle;
  logic [POOL_CORE-1:0]                POLMIF_AddrVld;
  logic [IDX_WIDTH*POOL_CORE-1:0]      POLMIF_Addr;
  logic [POOL_CORE-1:0]                MIFPOL_AddrRdy;
  logic                                MIFGLB_AddrVld;
  logic [IDX_WIDTH-1:0]                MIFGLB_Addr;
  logic                                GLBMIF_AddrRdy;
  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] GLBMIF_Fm;
  logic                                GLBMIF_FmVld;
  logic                                MIFGLB_FmRdy;
  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] MIFPOL_Fm;
  logic [POOL_CORE-1:0]                MIFPOL_FmVld;
  logic [POOL_CORE-1:0]                POLMIF_FmRdy;

  // The scheduler is the slave side; cores, GLB and CCU drive the master side.
  modport slave (
    input  CCUMIF_PortEn, POLMIF_AddrVld, POLMIF_Addr, GLBMIF_AddrRdy,
           GLBMIF_Fm, GLBMIF_FmVld, POLMIF_FmRdy,
    output MIFCCU_Idle, MIFPOL_AddrRdy, MIFGLB_AddrVld, MIFGLB_Addr,
           MIFGLB_FmRdy, MIFPOL_Fm, MIFPOL_FmVld
  );

  modport master (
    output CCUMIF_PortEn, POLMIF_AddrVld, POLMIF_Addr, GLBMIF_AddrRdy,
           GLBMIF_Fm, GLBMIF_FmVld, POLMIF_FmRdy,
    input  MIFCCU_Idle, MIFPOL_AddrRdy, MIFGLB_AddrVld, MIFGLB_Addr,
           MIFGLB_FmRdy, MIFPOL_Fm, MIFPOL_FmVld
  );

endinterface

// File: rtl/pol_rd_sched.sv
// Round-robin read scheduler: pooling cores -> single GLB read port, with
// per-port credits and an in-order tag FIFO steering returned words back.
module pol_rd_sched #(
  parameter int POOL_CORE      = 6,
  parameter int POOL_COMP_CORE = 64,
  parameter int IDX_WIDTH      = 10,
  parameter int ACT_WIDTH      = 8,
  parameter int MAX_OUTS       = 4,
  parameter int TAG_DEPTH      = 8
) (
  input  logic          clk,
  input  logic          rst,
  pol_rd_sched_if.slave bus
);

  localparam int PW   = (POOL_CORE > 1) ? $clog2(POOL_CORE) : 1;
  localparam int CW   = $clog2(MAX_OUTS + 1);
  localparam int AW   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int NW   = AW + 1;
  localparam int FM_W = ACT_WIDTH * POOL_COMP_CORE;

  typedef logic [PW-1:0] tag_t;

  logic [CW-1:0]        credit_q [POOL_CORE];
  logic [CW-1:0]        credit_d [POOL_CORE];
  tag_t                 rr_ptr_q, rr_ptr_d;
  logic                 addr_vld_q, addr_vld_d;
  logic [IDX_WIDTH-1:0] addr_q, addr_d;

  tag_t                 tag_mem [TAG_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]        count_q, count_d;

  logic [POOL_CORE-1:0] eligible;
  logic [POOL_CORE-1:0] addr_rdy;
  logic [POOL_CORE-1:0] fm_vld;
  logic                 fm_rdy;
  logic                 slot_free;
  logic                 fifo_full, fifo_empty;
  logic                 grant_vld;
  tag_t                 grant_idx;
  tag_t                 head_tag;
  logic                 push, pop;
  logic [FM_W-1:0]      fm_word;
  int                   j;

  assign fifo_full  = (count_q == NW'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_tag   = tag_mem[rd_ptr_q];
  assign slot_free  = !addr_vld_q || bus.GLBMIF_AddrRdy;

  // Full check uses the pre-pop count, so a same-cycle pop never enables a grant.
  always_comb begin
    for (int k = 0; k < POOL_CORE; k++) begin
      eligible[k] = bus.POLMIF_AddrVld[k] && bus.CCUMIF_PortEn[k] &&
                    (credit_q[k] < CW'(MAX_OUTS)) && !fifo_full;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int i = 0; i < POOL_CORE; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= POOL_CORE) j = j - POOL_CORE;
      if (!grant_vld && slot_free && eligible[j]) begin
        grant_vld = 1'b1;
        grant_idx = tag_t'(j);
      end
    end
  end

  always_comb begin
    addr_rdy = '0;
    if (grant_vld) addr_rdy[grant_idx] = 1'b1;
  end

  // Return path is purely combinational: head tag steers valid and ready.
  always_comb begin
    fm_vld = '0;
    fm_rdy = 1'b0;
    if (!fifo_empty) begin
      fm_vld[head_tag] = bus.GLBMIF_FmVld;
      fm_rdy           = bus.POLMIF_FmRdy[head_tag];
    end
  end

  assign push = grant_vld;
  assign pop  = bus.GLBMIF_FmVld && fm_rdy;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    addr_vld_d = addr_vld_q;
    addr_d     = addr_q;
    if (slot_free) begin
      addr_vld_d = grant_vld;
      if (grant_vld) begin
        addr_d   = bus.POLMIF_Addr[int'(grant_idx)*IDX_WIDTH +: IDX_WIDTH];
        rr_ptr_d = (grant_idx == tag_t'(POOL_CORE - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < POOL_CORE; k++) begin
      credit_d[k] = credit_q[k];
      case ({grant_vld && (grant_idx == tag_t'(k)), pop && (head_tag == tag_t'(k))})
        2'b10:   credit_d[k] = credit_q[k] + 1'b1;
        2'b01:   credit_d[k] = credit_q[k] - 1'b1;
        default: credit_d[k] = credit_q[k];
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < POOL_CORE; k++) credit_q[k] <= '0;
      rr_ptr_q   <= '0;
      addr_vld_q <= 1'b0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      for (int k = 0; k < POOL_CORE; k++) credit_q[k] <= credit_d[k];
      rr_ptr_q   <= rr_ptr_d;
      addr_vld_q <= addr_vld_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: tag storage is not reset; the count decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= grant_idx;
  end

  assign fm_word            = bus.GLBMIF_Fm;
  assign bus.MIFPOL_Fm      = fm_word;
  assign bus.MIFPOL_FmVld   = fm_vld;
  assign bus.MIFGLB_FmRdy   = fm_rdy;
  assign bus.MIFPOL_AddrRdy = addr_rdy;
  assign bus.MIFGLB_AddrVld = addr_vld_q;
  assign bus.MIFGLB_Addr    = addr_q;
  assign bus.MIFCCU_Idle    = fifo_empty && !addr_vld_q;

endmodule

// File: tb/tb_pol_rd_sched.sv
// Directed bench for pol_rd_sched: a vector table for round-robin issue and
// in-order return, plus hand sequences for credit, FIFO-full, stall and fencing.
module tb_pol_rd_sched;

  localparam int NC = 6;
  localparam int CC = 64;
  localparam int IW = 10;
  localparam int AW = 8;

  logic clk;
  logic rst;

  pol_rd_sched_if #(.POOL_CORE(NC), .POOL_COMP_CORE(CC), .IDX_WIDTH(IW), .ACT_WIDTH(AW)) bus   ();
  pol_rd_sched_if #(.POOL_CORE(NC), .POOL_COMP_CORE(CC), .IDX_WIDTH(IW), .ACT_WIDTH(AW)) bus_f ();

  pol_rd_sched #(.POOL_CORE(NC), .POOL_COMP_CORE(CC), .IDX_WIDTH(IW), .ACT_WIDTH(AW),
                 .MAX_OUTS(4), .TAG_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pol_rd_sched #(.POOL_CORE(NC), .POOL_COMP_CORE(CC), .IDX_WIDTH(IW), .ACT_WIDTH(AW),
                 .MAX_OUTS(4), .TAG_DEPTH(4)) dut_f (
    .clk (clk),
    .rst (rst),
    .bus (bus_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] vld;
    logic [NC-1:0] en;
    logic          addr_rdy;
    logic          fm_vld;
    logic [NC-1:0] fm_rdy;
    logic [NC-1:0] exp_grant;
    logic          exp_avld;
    logic [IW-1:0] exp_addr;
    logic [NC-1:0] exp_fmvld;
    logic          exp_fmrdy;
    logic          exp_idle;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [IW-1:0] addr_of(input int k);
    return IW'(k * 37 + 5);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] fm_exp [NC];
    // Expected return order for the FIFO-full scenario: tags 1,0,1,0.
    for (int i = 0; i < NC; i++) fm_exp[i] = '0;

    rst = 1'b1;
    bus.CCUMIF_PortEn  = '1;
    bus.POLMIF_AddrVld = '0;
    bus.GLBMIF_AddrRdy = 1'b1;
    bus.GLBMIF_FmVld   = 1'b0;
    bus.POLMIF_FmRdy   = '1;
    bus.GLBMIF_Fm      = {16{32'hA5C3_1E70}};
    bus_f.CCUMIF_PortEn  = '1;
    bus_f.POLMIF_AddrVld = '0;
    bus_f.GLBMIF_AddrRdy = 1'b1;
    bus_f.GLBMIF_FmVld   = 1'b0;
    bus_f.POLMIF_FmRdy   = '1;
    bus_f.GLBMIF_Fm      = '0;
    for (int k = 0; k < NC; k++) begin
      bus.POLMIF_Addr[k*IW +: IW]   = addr_of(k);
      bus_f.POLMIF_Addr[k*IW +: IW] = addr_of(k);
    end

    // Round-robin table: 7 grants 0..5,0 then 7 in-order returns.
    for (int i = 0; i < NV; i++) begin
      vecs[i].vld       = (i <= 6) ? 6'h3f : 6'h00;
      vecs[i].en        = 6'h3f;
      vecs[i].addr_rdy  = 1'b1;
      vecs[i].fm_vld    = (i >= 7 && i <= 13);
      vecs[i].fm_rdy    = 6'h3f;
      vecs[i].exp_grant = (i <= 6) ? NC'(1 << (i % NC)) : '0;
      vecs[i].exp_avld  = (i >= 1 && i <= 7);
      vecs[i].exp_addr  = (i == 0) ? '0 : (i <= 7) ? addr_of((i - 1) % NC) : addr_of(0);
      vecs[i].exp_fmvld = (i >= 7 && i <= 13) ? NC'(1 << ((i - 7) % NC)) : '0;
      vecs[i].exp_fmrdy = (i >= 1 && i <= 13);
      vecs[i].exp_idle  = (i == 0 || i == 14);
    end

    // Reset: two cycles asserted.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_idle", bus.MIFCCU_Idle, 1);
    check("rst_avld", bus.MIFGLB_AddrVld, 0);
    check("rst_addr", bus.MIFGLB_Addr, 0);
    check("rst_grant", bus.MIFPOL_AddrRdy, 0);
    check("rst_fmrdy", bus.MIFGLB_FmRdy, 0);
    check("rst_fmvld", bus.MIFPOL_FmVld, 0);
    for (int k = 0; k < NC; k++) check($sformatf("rst_credit%0d", k), dut.credit_q[k], 0);
    tick();

    for (int i = 0; i < NV; i++) begin
      bus.POLMIF_AddrVld = vecs[i].vld;
      bus.CCUMIF_PortEn  = vecs[i].en;
      bus.GLBMIF_AddrRdy = vecs[i].addr_rdy;
      bus.GLBMIF_FmVld   = vecs[i].fm_vld;
      bus.POLMIF_FmRdy   = vecs[i].fm_rdy;
      #1;
      check($sformatf("rr%0d_grant", i), bus.MIFPOL_AddrRdy, vecs[i].exp_grant);
      check($sformatf("rr%0d_avld", i),  bus.MIFGLB_AddrVld, vecs[i].exp_avld);
      check($sformatf("rr%0d_addr", i),  bus.MIFGLB_Addr,    vecs[i].exp_addr);
      check($sformatf("rr%0d_fmvld", i), bus.MIFPOL_FmVld,   vecs[i].exp_fmvld);
      check($sformatf("rr%0d_fmrdy", i), bus.MIFGLB_FmRdy,   vecs[i].exp_fmrdy);
      check($sformatf("rr%0d_idle", i),  bus.MIFCCU_Idle,    vecs[i].exp_idle);
      if (i == 7) check("fm_bcast", bus.MIFPOL_Fm === {16{32'hA5C3_1E70}}, 1);
      tick();
    end

    // Credit limit on port 2: four grants, stop, one return frees a fifth.
    bus.POLMIF_AddrVld = 6'b000100;
    for (int g = 0; g < 4; g++) begin
      #1;
      check($sformatf("cred_grant%0d", g), bus.MIFPOL_AddrRdy, 6'b000100);
      tick();
    end
    bus.GLBMIF_FmVld = 1'b1;
    #1;
    check("cred_full_nogrant", bus.MIFPOL_AddrRdy, 0);
    check("cred_ret_fmvld", bus.MIFPOL_FmVld, 6'b000100);
    check("cred_credit2_max", dut.credit_q[2], 4);
    tick();
    bus.GLBMIF_FmVld = 1'b0;
    #1;
    check("cred_freed_grant", bus.MIFPOL_AddrRdy, 6'b000100);
    tick();
    bus.POLMIF_AddrVld = '0;
    for (int r = 0; r < 4; r++) begin
      bus.GLBMIF_FmVld = 1'b1;
      #1;
      check($sformatf("cred_drain%0d", r), bus.MIFPOL_FmVld, 6'b000100);
      tick();
    end
    bus.GLBMIF_FmVld = 1'b0;
    #1;
    check("cred_idle", bus.MIFCCU_Idle, 1);
    check("cred_credit2_zero", dut.credit_q[2], 0);

    // GLB address backpressure: address holds, no grant while slot busy.
    bus.POLMIF_AddrVld = 6'b000010;
    #1;
    check("stall_grant0", bus.MIFPOL_AddrRdy, 6'b000010);
    tick();
    bus.GLBMIF_AddrRdy = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #1;
      check($sformatf("stall%0d_nogrant", s), bus.MIFPOL_AddrRdy, 0);
      check($sformatf("stall%0d_avld", s), bus.MIFGLB_AddrVld, 1);
      check($sformatf("stall%0d_addr", s), bus.MIFGLB_Addr, addr_of(1));
      tick();
    end
    bus.GLBMIF_AddrRdy = 1'b1;
    #1;
    check("stall_release_grant", bus.MIFPOL_AddrRdy, 6'b000010);
    tick();
    bus.POLMIF_AddrVld = '0;
    for (int r = 0; r < 2; r++) begin
      bus.GLBMIF_FmVld = 1'b1;
      #1;
      check($sformatf("stall_drain%0d", r), bus.MIFPOL_FmVld, 6'b000010);
      tick();
    end
    bus.GLBMIF_FmVld = 1'b0;

    // Return backpressure on head tag 3.
    bus.POLMIF_AddrVld = 6'b001000;
    #1;
    check("bp_grant3", bus.MIFPOL_AddrRdy, 6'b001000);
    tick();
    bus.POLMIF_AddrVld = '0;
    bus.GLBMIF_FmVld   = 1'b1;
    bus.POLMIF_FmRdy   = 6'b110111;
    for (int h = 0; h < 3; h++) begin
      #1;
      check($sformatf("bp%0d_fmvld", h), bus.MIFPOL_FmVld, 6'b001000);
      check($sformatf("bp%0d_fmrdy", h), bus.MIFGLB_FmRdy, 0);
      check($sformatf("bp%0d_credit3", h), dut.credit_q[3], 1);
      tick();
    end
    bus.POLMIF_FmRdy = '1;
    #1;
    check("bp_release_fmrdy", bus.MIFGLB_FmRdy, 1);
    tick();
    bus.GLBMIF_FmVld = 1'b0;
    #1;
    check("bp_credit3_dec", dut.credit_q[3], 0);
    check("bp_idle", bus.MIFCCU_Idle, 1);

    // Port 4 fenced with two reads outstanding.
    bus.POLMIF_AddrVld = 6'b010000;
    for (int g = 0; g < 2; g++) begin
      #1;
      check($sformatf("dis_grant%0d", g), bus.MIFPOL_AddrRdy, 6'b010000);
      tick();
    end
    bus.CCUMIF_PortEn = 6'b101111;
    for (int r = 0; r < 2; r++) begin
      bus.GLBMIF_FmVld = 1'b1;
      #1;
      check($sformatf("dis%0d_nogrant", r), bus.MIFPOL_AddrRdy, 0);
      check($sformatf("dis%0d_fmvld", r), bus.MIFPOL_FmVld, 6'b010000);
      check($sformatf("dis%0d_idle", r), bus.MIFCCU_Idle, 0);
      tick();
    end
    bus.GLBMIF_FmVld = 1'b0;
    #1;
    check("dis_nogrant_after", bus.MIFPOL_AddrRdy, 0);
    check("dis_idle", bus.MIFCCU_Idle, 1);
    bus.CCUMIF_PortEn  = '1;
    bus.POLMIF_AddrVld = '0;

    // Tag FIFO full on the 4-deep instance: grants 0,1,0,1 then blocked.
    fm_exp[0] = 6'b000010;
    fm_exp[1] = 6'b000001;
    fm_exp[2] = 6'b000010;
    fm_exp[3] = 6'b000001;
    bus_f.POLMIF_AddrVld = 6'b000011;
    for (int g = 0; g < 4; g++) begin
      #1;
      check($sformatf("ff_grant%0d", g), bus_f.MIFPOL_AddrRdy, (g % 2 == 0) ? 6'b000001 : 6'b000010);
      tick();
    end
    bus_f.GLBMIF_FmVld = 1'b1;
    #1;
    check("ff_full_nogrant", bus_f.MIFPOL_AddrRdy, 0);
    check("ff_pop_fmvld", bus_f.MIFPOL_FmVld, 6'b000001);
    tick();
    bus_f.GLBMIF_FmVld = 1'b0;
    #1;
    check("ff_next_grant", bus_f.MIFPOL_AddrRdy, 6'b000001);
    tick();
    bus_f.POLMIF_AddrVld = '0;
    for (int r = 0; r < 4; r++) begin
      bus_f.GLBMIF_FmVld = 1'b1;
      #1;
      check($sformatf("ff_drain%0d", r), bus_f.MIFPOL_FmVld, fm_exp[r]);
      tick();
    end
    bus_f.GLBMIF_FmVld = 1'b0;
    #1;
    check("ff_idle", bus_f.MIFCCU_Idle, 1);

    // Reset mid-operation discards tags and credits.
    bus.POLMIF_AddrVld = 6'b000001;
    #1;
    check("mrst_grant", bus.MIFPOL_AddrRdy, 6'b000001);
    tick();
    bus.POLMIF_AddrVld = '0;
    #1;
    check("mrst_busy", bus.MIFCCU_Idle, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_idle", bus.MIFCCU_Idle, 1);
    check("mrst_avld", bus.MIFGLB_AddrVld, 0);
    check("mrst_fmrdy", bus.MIFGLB_FmRdy, 0);
    check("mrst_credit0", dut.credit_q[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
